// File: rtl/full_adder_unit.sv
// full_adder_unit
// Registered WIDTH-bit ripple-carry adder with a valid flag.
// The combinational datapath is a chain of 1-bit full-adder cells
// (c[0] = cin); the result is captured in one output register stage.
//
// Ports:
//   clk       : clock, all state updates on the rising edge
//   rst       : synchronous active-high reset, takes priority over in_valid
//   in_valid  : a, b and cin are valid this cycle
//   a, b      : WIDTH-bit unsigned operands
//   cin       : carry into bit 0
//   out_valid : sum/carry hold a new result (one-cycle pulse per input)
//   sum       : registered sum bits
//   carry     : registered carry-out from bit WIDTH-1
module full_adder_unit #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  logic [WIDTH-1:0] sum_next;
  logic             carry_next;

  // Ripple chain: carry_next carries c[i] into cell i and ends up as
  // c[WIDTH], the carry-out of the top cell.
  always_comb begin
    sum_next   = '0;
    carry_next = cin;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      sum_next[i] = a[i] ^ b[i] ^ carry_next;
      carry_next  = (a[i] & b[i]) | (a[i] & carry_next) | (b[i] & carry_next);
    end
  end

  // Result registers load only on valid input and hold otherwise;
  // out_valid is a pure one-cycle-delayed copy of in_valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      carry     <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum   <= sum_next;
        carry <= carry_next;
      end
    end
  end

endmodule

// File: tb/tb_full_adder_unit.sv
// tb_full_adder_unit
// Self-checking bench for full_adder_unit at WIDTH = 1, 8 and 16.
// Expected results come from plain integer arithmetic a + b + cin.
module tb_full_adder_unit;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // WIDTH = 1 instance
  logic       v1_in = 1'b0;
  logic [0:0] a1 = '0, b1 = '0;
  logic       c1 = 1'b0;
  logic       v1_out;
  logic [0:0] s1;
  logic       k1;

  // WIDTH = 8 instance
  logic       v8_in = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       c8 = 1'b0;
  logic       v8_out;
  logic [7:0] s8;
  logic       k8;

  // WIDTH = 16 instance
  logic        v16_in = 1'b0;
  logic [15:0] a16 = '0, b16 = '0;
  logic        c16 = 1'b0;
  logic        v16_out;
  logic [15:0] s16;
  logic        k16;

  full_adder_unit #(.WIDTH(1)) u_w1 (
    .clk(clk), .rst(rst), .in_valid(v1_in), .a(a1), .b(b1), .cin(c1),
    .out_valid(v1_out), .sum(s1), .carry(k1)
  );

  full_adder_unit #(.WIDTH(8)) u_w8 (
    .clk(clk), .rst(rst), .in_valid(v8_in), .a(a8), .b(b8), .cin(c8),
    .out_valid(v8_out), .sum(s8), .carry(k8)
  );

  full_adder_unit #(.WIDTH(16)) u_w16 (
    .clk(clk), .rst(rst), .in_valid(v16_in), .a(a16), .b(b16), .cin(c16),
    .out_valid(v16_out), .sum(s16), .carry(k16)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    v1_in = 1'b1; a1 = 1'b1; b1 = 1'b1; c1 = 1'b1;
    v8_in = 1'b1; a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1;
    v16_in = 1'b1; a16 = 16'hFFFF; b16 = 16'h1234; c16 = 1'b1;
    step();
    step();
    checks++;
    if ({v1_out, s1, k1} !== 3'b000) begin
      failures++;
      $display("FAIL reset_w1: got v=%b s=%b c=%b, want 0 0 0", v1_out, s1, k1);
    end
    checks++;
    if ({v8_out, s8, k8} !== 10'b0) begin
      failures++;
      $display("FAIL reset_w8: got v=%b s=%h c=%b, want 0 00 0", v8_out, s8, k8);
    end
    checks++;
    if ({v16_out, s16, k16} !== 18'b0) begin
      failures++;
      $display("FAIL reset_w16: got v=%b s=%h c=%b, want 0 0000 0", v16_out, s16, k16);
    end
    v1_in = 1'b0; v8_in = 1'b0; v16_in = 1'b0;
    rst = 1'b0;
    step();
  endtask

  task automatic test_truth_table();
    int exp;
    for (int i = 0; i < 8; i++) begin
      a1 = 1'(i >> 2); b1 = 1'(i >> 1); c1 = 1'(i);
      v1_in = 1'b1;
      exp = ((i >> 2) & 1) + ((i >> 1) & 1) + (i & 1);
      step();
      checks++;
      if (v1_out !== 1'b1 || s1 !== 1'(exp) || k1 !== 1'(exp >> 1)) begin
        failures++;
        $display("FAIL truth_%0d%0d%0d: got v=%b s=%b c=%b, want v=1 s=%0d c=%0d",
                 (i >> 2) & 1, (i >> 1) & 1, i & 1, v1_out, s1, k1, exp & 1, (exp >> 1) & 1);
      end
    end
    v1_in = 1'b0;
    step();
  endtask

  task automatic test_boundaries();
    logic [7:0] ta [4] = '{8'hFF, 8'hFF, 8'h00, 8'h5A};
    logic [7:0] tb [4] = '{8'h01, 8'hFF, 8'h00, 8'hA5};
    logic       tc [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
    logic [7:0] es [4] = '{8'h00, 8'hFF, 8'h00, 8'h00};
    logic       ec [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      a8 = ta[i]; b8 = tb[i]; c8 = tc[i]; v8_in = 1'b1;
      step();
      checks++;
      if (v8_out !== 1'b1 || s8 !== es[i] || k8 !== ec[i]) begin
        failures++;
        $display("FAIL boundary_%0d: got v=%b s=%h c=%b, want v=1 s=%h c=%b",
                 i, v8_out, s8, k8, es[i], ec[i]);
      end
    end
    v8_in = 1'b0;
    step();
  endtask

  task automatic test_valid_gating();
    a8 = 8'h12; b8 = 8'h34; c8 = 1'b0; v8_in = 1'b1;
    step();
    checks++;
    if (v8_out !== 1'b1 || s8 !== 8'h46 || k8 !== 1'b0) begin
      failures++;
      $display("FAIL gate_first: got v=%b s=%h c=%b, want v=1 s=46 c=0", v8_out, s8, k8);
    end
    a8 = 8'hFF; b8 = 8'hFF; c8 = 1'b1; v8_in = 1'b0;
    step();
    checks++;
    if (v8_out !== 1'b0 || s8 !== 8'h46 || k8 !== 1'b0) begin
      failures++;
      $display("FAIL gate_hold: got v=%b s=%h c=%b, want v=0 s=46 c=0", v8_out, s8, k8);
    end
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b1; v8_in = 1'b1;
    step();
    checks++;
    if (v8_out !== 1'b1 || s8 !== 8'h01 || k8 !== 1'b1) begin
      failures++;
      $display("FAIL gate_second: got v=%b s=%h c=%b, want v=1 s=01 c=1", v8_out, s8, k8);
    end
    v8_in = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b1; v1_in = 1'b1;
    step();
    checks++;
    if (v1_out !== 1'b1 || s1 !== 1'b1 || k1 !== 1'b1) begin
      failures++;
      $display("FAIL pre_reset: got v=%b s=%b c=%b, want 1 1 1", v1_out, s1, k1);
    end
    rst = 1'b1;
    step();
    checks++;
    if (v1_out !== 1'b0 || s1 !== 1'b0 || k1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid: got v=%b s=%b c=%b, want 0 0 0", v1_out, s1, k1);
    end
    rst = 1'b0;
    a1 = 1'b1; b1 = 1'b1; c1 = 1'b0;
    step();
    checks++;
    if (v1_out !== 1'b1 || s1 !== 1'b0 || k1 !== 1'b1) begin
      failures++;
      $display("FAIL post_reset: got v=%b s=%b c=%b, want 1 0 1", v1_out, s1, k1);
    end
    v1_in = 1'b0;
    step();
  endtask

  task automatic test_random();
    logic [16:0] held;
    logic        exp_v;
    int          bad;
    rst = 1'b1;
    v16_in = 1'b0;
    step();
    rst = 1'b0;
    held = '0;
    bad = 0;
    for (int n = 0; n < 1000; n++) begin
      v16_in = 1'($urandom_range(0, 3) != 0);
      a16 = 16'($urandom);
      b16 = 16'($urandom);
      c16 = 1'($urandom);
      // Occasionally force extremes so the carry-out gets exercised hard
      if (n % 97 == 0) begin a16 = '1; b16 = '1; end
      exp_v = v16_in;
      if (v16_in) held = 17'(int'(a16) + int'(b16) + int'(c16));
      step();
      checks++;
      if (v16_out !== exp_v || {k16, s16} !== held) begin
        failures++;
        if (bad < 10)
          $display("FAIL random_%0d: got v=%b {c,s}=%h, want v=%b {c,s}=%h",
                   n, v16_out, {k16, s16}, exp_v, held);
        bad++;
      end
    end
    v16_in = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_truth_table();
    test_boundaries();
    test_valid_gating();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
